// File: rtl/if_pc_unit_pkg.sv
// Shared MIPS fetch-stage constants: the special instruction words and the
// fetch FSM state encoding.
package if_pc_unit_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/if_pc_unit_if.sv
// Fetch-stage bus: control/redirect inputs and the IF/ID outputs.
// master = pipeline control driving the fetch unit, slave = if_pc_unit.
interface if_pc_unit_if #(
  parameter int NBITS = 32
);
  logic             i_enable;
  logic             i_stall;
  logic             i_branch_taken;
  logic [NBITS-1:0] i_branch_addr;
  logic             i_jump;
  logic [NBITS-1:0] i_jump_addr;
  logic             i_jr;
  logic [NBITS-1:0] i_jr_addr;
  logic [NBITS-1:0] i_instr;
  logic [NBITS-1:0] o_pc;
  logic [NBITS-1:0] o_pc4;
  logic [NBITS-1:0] o_instr;
  logic             o_valid;
  logic             o_halt;

  modport master (
    output i_enable, i_stall, i_branch_taken, i_branch_addr, i_jump, i_jump_addr,
           i_jr, i_jr_addr, i_instr,
    input  o_pc, o_pc4, o_instr, o_valid, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_branch_taken, i_branch_addr, i_jump, i_jump_addr,
           i_jr, i_jr_addr, i_instr,
    output o_pc, o_pc4, o_instr, o_valid, o_halt
  );

endinterface

// File: rtl/if_pc_unit_pc_next_mux.sv
// Next-PC selection, purely combinational.
// Ports: i_pc current PC; stall/jr/jump/branch requests with their targets;
// o_next_pc selected next PC, o_pc4 = i_pc+4 (wraps), o_redirect = a
// redirect wins this cycle (never while stalled).
module pc_next_mux #(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] i_pc,
  input  logic             i_stall,
  input  logic             i_jr,
  input  logic [NBITS-1:0] i_jr_addr,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_addr,
  input  logic             i_branch_taken,
  input  logic [NBITS-1:0] i_branch_addr,
  output logic [NBITS-1:0] o_next_pc,
  output logic [NBITS-1:0] o_pc4,
  output logic             o_redirect
);

  assign o_pc4 = i_pc + NBITS'(4);

  always_comb begin
    o_next_pc  = o_pc4;
    o_redirect = 1'b0;
    if (i_stall) begin
      o_next_pc = i_pc;
    end else if (i_jr) begin
      o_next_pc  = i_jr_addr;
      o_redirect = 1'b1;
    end else if (i_jump) begin
      o_next_pc  = i_jump_addr;
      o_redirect = 1'b1;
    end else if (i_branch_taken) begin
      o_next_pc  = i_branch_addr;
      o_redirect = 1'b1;
    end
  end

endmodule

// File: rtl/if_pc_unit.sv
// Instruction-fetch unit: PC register, IF/ID pipeline register and the
// RUN/HALTED fetch FSM.
// Ports: i_clk, i_reset (sync, active-high); bus (slave) carries enable,
// stall, redirect requests, fetched instruction, and the PC / IF/ID outputs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal fetch: advance, redirect or stall each enabled cycle
// ST_HALTED | HALT captured; PC frozen, IF/ID fed NOPs until reset
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter logic [NBITS-1:0] RESET_PC = '0
) (
  input logic         i_clk,
  input logic         i_reset,
  if_pc_unit_if.slave bus
);

  localparam logic [NBITS-1:0] NOP_W  = NBITS'(NOP_INSTR);
  localparam logic [NBITS-1:0] HALT_W = NBITS'(HALT_INSTR);

  pc_state_e        state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] pc4_q, pc4_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;

  logic [NBITS-1:0] next_pc;
  logic [NBITS-1:0] pc_plus4;
  logic             redirect;

  pc_next_mux #(.NBITS(NBITS)) u_pc_next_mux (
    .i_pc           (pc_q),
    .i_stall        (bus.i_stall),
    .i_jr           (bus.i_jr),
    .i_jr_addr      (bus.i_jr_addr),
    .i_jump         (bus.i_jump),
    .i_jump_addr    (bus.i_jump_addr),
    .i_branch_taken (bus.i_branch_taken),
    .i_branch_addr  (bus.i_branch_addr),
    .o_next_pc      (next_pc),
    .o_pc4          (pc_plus4),
    .o_redirect     (redirect)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bus.i_enable) begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.i_stall) begin
            // hold everything; a HALT seen here only counts once it advances
          end else if (redirect) begin
            // wrong-path fetch (HALT included) is squashed
            pc_d    = next_pc;
            pc4_d   = pc_plus4;
            instr_d = NOP_W;
            valid_d = 1'b0;
          end else begin
            pc4_d   = pc_plus4;
            instr_d = bus.i_instr;
            valid_d = 1'b1;
            if (bus.i_instr == HALT_W) begin
              state_d = ST_HALTED;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        ST_HALTED: begin
          instr_d = NOP_W;
          valid_d = 1'b0;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= NOP_W;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_pc    = pc_q;
  assign bus.o_pc4   = pc4_q;
  assign bus.o_instr = instr_q;
  assign bus.o_valid = valid_q;
  assign bus.o_halt  = (state_q == ST_HALTED);

endmodule
